// File: rtl/psum_drain_ctrl.sv
// psum_drain_ctrl: drains one row of partial sums from a cluster psum GLB
// read port and presents it as a valid/ready stream with backpressure.
// Read issue is credit-based, so the 2-entry return FIFO can never overflow.
// Optional build macro PSUM_RELU_EN: negative words (MSB set) are output as 0.
//
// state | meaning
// IDLE  | waiting for drain_start
// READ  | issuing X_dim GLB reads as credit allows
// FLUSH | all reads issued, waiting for in-flight data and FIFO to empty
// DONE  | one-cycle drain_done pulse, busy low
module psum_drain_ctrl #(
  parameter int DATA_BITWIDTH  = 16,
  parameter int ADDR_BITWIDTH  = 10,
  parameter int X_dim          = 8,
  parameter int ROW_W          = 3,
  parameter int PSUM_LOAD_ADDR = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     drain_start,
  input  logic [ROW_W-1:0]         row_idx,
  output logic                     r_req_psum,
  output logic [ADDR_BITWIDTH-1:0] r_addr_psum,
  input  logic [DATA_BITWIDTH-1:0] r_data_psum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_BITWIDTH-1:0] out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     drain_done,
  output logic                     start_err
);

  localparam int CNT_W = $clog2(X_dim + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(X_dim - 1);

  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

  state_t state, state_next;

  logic [ADDR_BITWIDTH-1:0] base;
  logic [ADDR_BITWIDTH-1:0] row_base;
  logic [CNT_W-1:0]         issue_cnt;
  logic [CNT_W-1:0]         elem_cnt;
  logic                     inflight;

  logic [DATA_BITWIDTH-1:0] fifo_data [2];
  logic [1:0]               fifo_last;
  logic                     wr_ptr;
  logic                     rd_ptr;
  logic [1:0]               fifo_count;

  logic                     issue;
  logic                     start_ok;
  logic                     push;
  logic                     pop;
  logic                     credit;
  logic [1:0]               occ_after;
  logic [DATA_BITWIDTH-1:0] head;
  logic [DATA_BITWIDTH-1:0] shaped;

  // Row base address wraps naturally into the GLB address space.
  assign row_base = ADDR_BITWIDTH'(PSUM_LOAD_ADDR + int'(row_idx) * X_dim);

  assign push      = inflight;
  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid & out_ready;

  // A word accepted this cycle returns its credit immediately; this keeps
  // the 1-cycle GLB loop at full rate with only two FIFO slots.
  assign occ_after = fifo_count - {1'b0, pop};
  assign credit    = (occ_after == 2'd0) || ((occ_after == 2'd1) && !inflight);

  assign r_req_psum  = issue;
  assign r_addr_psum = issue ? (base + ADDR_BITWIDTH'(issue_cnt)) : '0;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state decode and per-state outputs.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    busy       = 1'b0;
    drain_done = 1'b0;
    start_ok   = 1'b0;
    case (state)
      IDLE: begin
        if (drain_start) begin
          start_ok   = 1'b1;
          state_next = READ;
        end
      end
      READ: begin
        busy = 1'b1;
        if (credit) begin
          issue = 1'b1;
          if (issue_cnt == LAST_IDX) state_next = FLUSH;
        end
      end
      FLUSH: begin
        busy = 1'b1;
        if (!inflight && (occ_after == 2'd0)) state_next = DONE;
      end
      DONE: begin
        drain_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Row base, issue/element counters, in-flight flag and sticky start error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base      <= '0;
      issue_cnt <= '0;
      elem_cnt  <= '0;
      inflight  <= 1'b0;
      start_err <= 1'b0;
    end else begin
      inflight <= issue;
      if (drain_start && (state != IDLE)) start_err <= 1'b1;
      if (start_ok) begin
        base      <= row_base;
        issue_cnt <= '0;
        elem_cnt  <= '0;
      end else begin
        if (issue) issue_cnt <= issue_cnt + 1'b1;
        if (push)  elem_cnt  <= elem_cnt + 1'b1;
      end
    end
  end

  // Two-entry return FIFO; each entry carries its last-of-row flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last    <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      fifo_count   <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= r_data_psum;
        fifo_last[wr_ptr] <= (elem_cnt == LAST_IDX);
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Output word shaping from the FIFO head.
  always_comb begin
    head = fifo_data[rd_ptr];
`ifdef PSUM_RELU_EN
    if (head[DATA_BITWIDTH-1]) shaped = '0;
    else                       shaped = head;
`else
    shaped = head;
`endif
  end

  assign out_data = out_valid ? shaped : '0;
  assign out_last = out_valid & fifo_last[rd_ptr];

endmodule

// File: tb/tb_psum_drain_ctrl.sv
// Bench for psum_drain_ctrl: two instances (load address 0 and 1020) share
// all control stimulus; each has its own GLB responder and a reference model
// that predicts the address sequence, output stream and status pulses.
module tb_psum_drain_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        drain_start;
  logic [2:0]  row_idx;
  logic        out_ready;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [15:0] glb [1024];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [15:0] xform(input logic [15:0] w);
`ifdef PSUM_RELU_EN
    return w[15] ? 16'h0000 : w;
`else
    return w;
`endif
  endfunction

  task automatic chk_eq(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic        req, valid, last, busy_o, done, err;
    logic [9:0]  addr;
    logic [15:0] rdata, odata;
    logic        req_s;
    logic [9:0]  addr_s;
    int          mode = 0, out_idx = 0, outstanding = 0, max_out = 0;
    int          issue_n = 0, acc_n = 0, start_cyc = 0, first_valid = -1;
    int          first_acc = 0, last_acc = 0, done_cyc = 0;
    bit          err_exp = 0, stall = 0, pop = 0;
    logic [15:0] prev_data;
    logic        prev_last;
    int          addr_q[$];
    logic [15:0] data_q[$];
    int          addr_log [8];
    logic [15:0] acc_log [8];

    psum_drain_ctrl #(.PSUM_LOAD_ADDR(g == 0 ? 0 : 1020)) u_dut (
      .clk(clk), .reset_n(reset_n), .drain_start(drain_start), .row_idx(row_idx),
      .r_req_psum(req), .r_addr_psum(addr), .r_data_psum(rdata),
      .out_valid(valid), .out_ready(out_ready), .out_data(odata), .out_last(last),
      .busy(busy_o), .drain_done(done), .start_err(err)
    );

    // GLB: data for a request is presented during the following cycle.
    always @(negedge clk) begin
      req_s  = req;
      addr_s = addr;
    end
    always @(posedge clk) begin
      #1;
      rdata = req_s ? glb[addr_s] : 16'($urandom);
    end

    // Reference model and per-cycle compare.
    always @(negedge clk) begin : chk_proc
      int nxt;
      int base;
      if (!reset_n) begin
        mode = 0; out_idx = 0; outstanding = 0; err_exp = 0; stall = 0;
        addr_q.delete(); data_q.delete();
        chk_eq($sformatf("i%0d outputs in reset", g),
               {req, addr, valid, odata, last, busy_o, done, err}, 0);
      end else begin
        chk_eq($sformatf("i%0d busy", g), busy_o, mode == 1);
        chk_eq($sformatf("i%0d drain_done", g), done, mode == 2);
        chk_eq($sformatf("i%0d start_err", g), err, err_exp);
        if (done) done_cyc = cyc;
        pop = valid && out_ready;
        if (req) begin
          chk_eq($sformatf("i%0d read only while draining", g), (mode == 1) && (addr_q.size() > 0), 1);
          chk_eq($sformatf("i%0d read credit", g), (outstanding - int'(pop)) < 2, 1);
          if (addr_q.size() > 0) begin
            chk_eq($sformatf("i%0d r_addr", g), addr, addr_q[0]);
            void'(addr_q.pop_front());
          end
          if (issue_n < 8) addr_log[issue_n] = int'(addr);
          issue_n++;
        end
        if (stall) chk_eq($sformatf("i%0d valid held in stall", g), valid, 1);
        if (valid) begin
          if (first_valid < 0) first_valid = cyc;
          chk_eq($sformatf("i%0d word pending when valid", g), data_q.size() > 0, 1);
          if (data_q.size() > 0) begin
            chk_eq($sformatf("i%0d out_data", g), odata, data_q[0]);
            chk_eq($sformatf("i%0d out_last", g), last, out_idx == 7);
          end
          if (stall) begin
            chk_eq($sformatf("i%0d data stable in stall", g), odata, prev_data);
            chk_eq($sformatf("i%0d last stable in stall", g), last, prev_last);
          end
        end
        stall     = valid && !out_ready;
        prev_data = odata;
        prev_last = last;
        nxt = mode;
        if (pop && data_q.size() > 0) begin
          if (acc_n < 8) acc_log[acc_n] = odata;
          acc_n++;
          if (out_idx == 0) first_acc = cyc;
          if (out_idx == 7) last_acc = cyc;
          void'(data_q.pop_front());
          out_idx++;
          if (out_idx == 8 && mode == 1) nxt = 2;
        end
        outstanding = outstanding + int'(req) - int'(pop);
        if (outstanding > max_out) max_out = outstanding;
        if (mode == 2) nxt = 0;
        if (drain_start) begin
          if (mode == 0) begin
            base = (g == 0 ? 0 : 1020) + int'(row_idx) * 8;
            for (int i = 0; i < 8; i++) begin
              addr_q.push_back((base + i) % 1024);
              data_q.push_back(xform(glb[(base + i) % 1024]));
            end
            nxt = 1; out_idx = 0; issue_n = 0; acc_n = 0; max_out = 0;
            start_cyc = cyc; first_valid = -1;
          end else begin
            err_exp = 1;
          end
        end
        mode = nxt;
      end
    end
  end

  task automatic check_zero(input string tag);
    chk_eq({tag, " r_req_psum"}, g_inst[0].req, 0);
    chk_eq({tag, " r_addr_psum"}, g_inst[0].addr, 0);
    chk_eq({tag, " out_valid"}, g_inst[0].valid, 0);
    chk_eq({tag, " out_data"}, g_inst[0].odata, 0);
    chk_eq({tag, " busy"}, g_inst[0].busy_o, 0);
    chk_eq({tag, " start_err"}, g_inst[0].err, 0);
  endtask

  // One drain: optional 1,0,0,1 backpressure and optional second start 2 cycles later.
  task automatic drain(input int row, input bit bp, input int ov_row);
    int k;
    bit seen;
    k = 0;
    seen = 0;
    @(posedge clk); #1;
    drain_start = 1'b1;
    row_idx = 3'(row);
    out_ready = 1'b1;
    while (!seen && k < 300) begin
      @(negedge clk);
      if (g_inst[0].done) seen = 1;
      else begin
        @(posedge clk); #1;
        drain_start = (ov_row >= 0) && (k == 1);
        if (drain_start) row_idx = 3'(ov_row);
        out_ready = bp ? (((k + 1) % 4 == 0) || ((k + 1) % 4 == 3)) : 1'b1;
        k++;
      end
    end
    #1;
    drain_start = 1'b0;
    out_ready = 1'b1;
    chk_eq($sformatf("drain row %0d completes", row), seen, 1);
  endtask

  initial begin
    reset_n = 1'b0;
    drain_start = 1'b0;
    row_idx = '0;
    out_ready = 1'b1;
    for (int a = 0; a < 1024; a++) glb[a] = 16'(a + 100);
    glb[24] = 16'hFFFF;
    glb[25] = 16'h0005;
    glb[26] = 16'h8000;
    #3 check_zero("reset");
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;

    // Basic drain of row 2.
    drain(2, 0, -1);
    chk_eq("t1 first out_valid latency", g_inst[0].first_valid - g_inst[0].start_cyc, 3);
    chk_eq("t1 first address", g_inst[0].addr_log[0], 16);
    chk_eq("t1 last address", g_inst[0].addr_log[7], 23);
    chk_eq("t1 first word", g_inst[0].acc_log[0], 116);
    chk_eq("t1 last word", g_inst[0].acc_log[7], 123);
    chk_eq("t1 back-to-back words", g_inst[0].last_acc - g_inst[0].first_acc, 7);
    chk_eq("t1 done after last accept", g_inst[0].done_cyc - g_inst[0].last_acc, 1);

    // Backpressure.
    drain(2, 1, -1);
    chk_eq("t2 words accepted", g_inst[0].acc_n, 8);
    chk_eq("t2 last word", g_inst[0].acc_log[7], 123);
    chk_eq("t2 credit never exceeded", g_inst[0].max_out <= 2, 1);

    // Overlapping start is rejected and flagged.
    drain(2, 0, 5);
    chk_eq("t3 start_err set", g_inst[0].err, 1);
    chk_eq("t3 first word still row 2", g_inst[0].acc_log[0], 116);
    chk_eq("t3 last word still row 2", g_inst[0].acc_log[7], 123);
    drain(4, 0, -1);
    chk_eq("t3 later drain first word", g_inst[0].acc_log[0], 132);
    chk_eq("t3 start_err sticky", g_inst[0].err, 1);

    // Reset in the middle of a row.
    @(posedge clk); #1;
    drain_start = 1'b1;
    row_idx = 3'd2;
    @(posedge clk); #1;
    drain_start = 1'b0;
    for (int k = 0; k < 50 && g_inst[0].acc_n < 3; k++) begin
      @(negedge clk); #1;
    end
    chk_eq("t5 three words before reset", g_inst[0].acc_n, 3);
    #2 reset_n = 1'b0;
    #1 check_zero("t5 async reset");
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    drain(1, 0, -1);
    chk_eq("t5 first address after reset", g_inst[0].addr_log[0], 8);
    chk_eq("t5 first word after reset", g_inst[0].acc_log[0], 108);
    chk_eq("t5 words after reset", g_inst[0].acc_n, 8);

    // Address wrap on the instance loaded at 1020.
    drain(0, 0, -1);
    chk_eq("t4 wrap addr 0", g_inst[1].addr_log[0], 1020);
    chk_eq("t4 wrap addr 3", g_inst[1].addr_log[3], 1023);
    chk_eq("t4 wrap addr 4", g_inst[1].addr_log[4], 0);
    chk_eq("t4 wrap addr 7", g_inst[1].addr_log[7], 3);
    chk_eq("t4 wrap no stall", g_inst[1].last_acc - g_inst[1].first_acc, 7);
    chk_eq("t4 wrap no error", g_inst[1].err, 0);

    // Sign handling of output words.
    drain(3, 0, -1);
`ifdef PSUM_RELU_EN
    chk_eq("t6 word FFFF", g_inst[0].acc_log[0], 16'h0000);
    chk_eq("t6 word 0005", g_inst[0].acc_log[1], 16'h0005);
    chk_eq("t6 word 8000", g_inst[0].acc_log[2], 16'h0000);
`else
    chk_eq("t6 word FFFF", g_inst[0].acc_log[0], 16'hFFFF);
    chk_eq("t6 word 0005", g_inst[0].acc_log[1], 16'h0005);
    chk_eq("t6 word 8000", g_inst[0].acc_log[2], 16'h8000);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
